stopwatch_cmd_arbiter: RTL and testbench

- Shares stopwatch control between two requesters: local panel buttons (raw, asynchronous) and a remote host command port with a valid/ready handshake.
- Sits directly upstream of the stopwatch control FSM and drives its start/stop/reset inputs as clean single-cycle pulses.
- Filters commands against the FSM's current state and enforces ownership so requesters cannot interleave start/stop.

---
 rtl/stopwatch_cmd_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_stopwatch_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cmd_arbiter.sv
// stopwatch_cmd_arbiter
//   Shares stopwatch control between debounced local panel buttons and a
//   valid/ready host command port. Commands are filtered against the
//   stopwatch FSM state and against ownership. Surviving commands become
//   registered single-cycle start/stop/reset pulses.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   btn_start/stop/reset  raw asynchronous buttons, active high
//   host_cmd_valid/ready  host handshake, ready = no host command held
//   host_cmd[1:0]         01 start, 10 stop, 11 reset, 00 reserved (discarded)
//   fsm_state[1:0]        00 IDLE, 01 RUNNING, 10 PAUSED
//   cmd_start/stop/reset  one-cycle pulses to the stopwatch FSM
//   owner[1:0]            00 FREE, 01 LOCAL, 10 HOST
//   drop_count[7:0]       saturating count of dropped commands; present only
//                         when CMD_DROP_COUNT_EN is defined

// Per-button 2-flop synchronizer and debouncer. The debounced level flips
// after DB_CYCLES consecutive cycles that disagree with it. 'rise' is high
// for one cycle after a debounced 0->1 transition.
module stopwatch_cmd_btn_db #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1, s2, db, db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = db & ~db_d;
endmodule

module stopwatch_cmd_arbiter #(
    parameter int DB_CYCLES     = 1000,
    parameter int OWNER_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    input  logic       host_cmd_valid,
    input  logic [1:0] host_cmd,
    output logic       host_cmd_ready,
    input  logic [1:0] fsm_state,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_reset,
    output logic [1:0] owner
`ifdef CMD_DROP_COUNT_EN
   ,output logic [7:0] drop_count
`endif
);
    localparam int TW = (OWNER_TIMEOUT > 2) ? $clog2(OWNER_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(OWNER_TIMEOUT - 1);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;

    typedef enum logic [1:0] {OWN_FREE = 2'b00, OWN_LOCAL = 2'b01, OWN_HOST = 2'b10} owner_e;
    typedef enum logic [2:0] {SEL_NONE, SEL_LRST, SEL_HRST, SEL_LSTOP, SEL_LSTART,
                              SEL_HSTOP, SEL_HSTART} sel_e;

    // ---- button front end: bit 0 start, bit 1 stop, bit 2 reset ----
    logic [2:0] btn_raw, btn_rise, lp, lp_clr;
    assign btn_raw = {btn_reset, btn_stop, btn_start};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        stopwatch_cmd_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_raw[g]),
            .rise (btn_rise[g])
        );
    end

    // ---- host holding register ----
    logic       host_pend, host_clr;
    logic [1:0] host_cmd_q;
    logic       h_start, h_stop, h_rst;
    assign host_cmd_ready = ~host_pend;
    assign h_start = host_pend && (host_cmd_q == 2'b01);
    assign h_stop  = host_pend && (host_cmd_q == 2'b10);
    assign h_rst   = host_pend && (host_cmd_q == 2'b11);

    // ---- issue slot ----
    owner_e        owner_q, owner_d;
    logic [TW-1:0] tmr;
    logic          tmr_load;
    sel_e          sel;
    logic          is_start, is_stop, is_rst, sel_local, sel_host, pass, issue;
    logic          own_drop_l_start, own_drop_l_stop, own_drop_h;

    always_comb begin
        sel = SEL_NONE;
        if (lp[2])      sel = SEL_LRST;
        else if (h_rst) sel = SEL_HRST;
        else begin
            case (owner_q)
                OWN_LOCAL: begin
                    if (lp[1])      sel = SEL_LSTOP;
                    else if (lp[0]) sel = SEL_LSTART;
                end
                OWN_HOST: begin
                    if (h_stop)       sel = SEL_HSTOP;
                    else if (h_start) sel = SEL_HSTART;
                end
                default: begin
                    if (lp[1])        sel = SEL_LSTOP;
                    else if (lp[0])   sel = SEL_LSTART;
                    else if (h_stop)  sel = SEL_HSTOP;
                    else if (h_start) sel = SEL_HSTART;
                end
            endcase
        end
    end

    assign is_start  = (sel == SEL_LSTART) || (sel == SEL_HSTART);
    assign is_stop   = (sel == SEL_LSTOP)  || (sel == SEL_HSTOP);
    assign is_rst    = (sel == SEL_LRST)   || (sel == SEL_HRST);
    assign sel_local = (sel == SEL_LRST) || (sel == SEL_LSTOP) || (sel == SEL_LSTART);
    assign sel_host  = (sel == SEL_HRST) || (sel == SEL_HSTOP) || (sel == SEL_HSTART);
    assign pass = (is_start && (fsm_state != ST_RUN)) ||
                  (is_stop  && (fsm_state == ST_RUN)) ||
                  (is_rst   && (fsm_state != ST_IDLE));
    assign issue = pass;   // pass is only ever true for a selected command

    // Non-owner start/stop is discarded in parallel with the slot; it can
    // never issue while the other requester holds ownership.
    assign own_drop_l_start = (owner_q == OWN_HOST)  && lp[0];
    assign own_drop_l_stop  = (owner_q == OWN_HOST)  && lp[1];
    assign own_drop_h       = (owner_q == OWN_LOCAL) && (h_start || h_stop);

    assign lp_clr[0] = own_drop_l_start || (sel == SEL_LSTART);
    assign lp_clr[1] = own_drop_l_stop  || (sel == SEL_LSTOP);
    assign lp_clr[2] = (sel == SEL_LRST);
    assign host_clr  = own_drop_h || sel_host;

    // ---- ownership FSM ----
    always_comb begin
        owner_d  = owner_q;
        tmr_load = 1'b0;
        if (issue && is_rst) begin
            owner_d = OWN_FREE;
        end else if (issue) begin
            // a start/stop only issues from the owner or while FREE
            owner_d  = sel_local ? OWN_LOCAL : OWN_HOST;
            tmr_load = 1'b1;
        end else if ((owner_q != OWN_FREE) && (tmr == '0)) begin
            owner_d = OWN_FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner_q <= OWN_FREE;
        else        owner_q <= owner_d;
    end

    assign owner = owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr        <= '0;
            lp         <= '0;
            host_pend  <= 1'b0;
            host_cmd_q <= 2'b00;
            cmd_start  <= 1'b0;
            cmd_stop   <= 1'b0;
            cmd_reset  <= 1'b0;
        end else begin
            if (tmr_load)
                tmr <= TLOAD;
            else if ((owner_q != OWN_FREE) && (tmr != '0))
                tmr <= tmr - 1'b1;

            // a new edge arriving as the flag clears stays pending
            lp <= (lp & ~lp_clr) | btn_rise;

            if (host_clr) host_pend <= 1'b0;
            if (host_cmd_valid && host_cmd_ready && (host_cmd != 2'b00)) begin
                host_pend  <= 1'b1;
                host_cmd_q <= host_cmd;
            end

            cmd_start <= issue && is_start;
            cmd_stop  <= issue && is_stop;
            cmd_reset <= issue && is_rst;
        end
    end

`ifdef CMD_DROP_COUNT_EN
    logic       filt;
    logic [1:0] n_drop;
    logic [8:0] drop_sum;
    logic [7:0] drop_cnt;

    assign filt     = (sel != SEL_NONE) && !pass;
    assign n_drop   = 2'(own_drop_l_start) + 2'(own_drop_l_stop) + 2'(own_drop_h) + 2'(filt);
    assign drop_sum = {1'b0, drop_cnt} + {7'b0, n_drop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= 8'd0;
        else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign drop_count = drop_cnt;
`endif
endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
// Directed bench for stopwatch_cmd_arbiter (DB_CYCLES=4, OWNER_TIMEOUT=8).
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at the same point, so each check sees the registered state of that cycle.
module tb_stopwatch_cmd_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start, btn_stop, btn_reset;
    logic       host_cmd_valid;
    logic [1:0] host_cmd;
    logic       host_cmd_ready;
    logic [1:0] fsm_state;
    logic       cmd_start, cmd_stop, cmd_reset;
    logic [1:0] owner;
`ifdef CMD_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;
    int n_start, n_stop, n_rst;
    logic [1:0] own_at;

    localparam logic [1:0] FREE = 2'b00, LOCAL = 2'b01, HOST = 2'b10;
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01;

    always #5 clk = ~clk;

    stopwatch_cmd_arbiter #(.DB_CYCLES(4), .OWNER_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start     (btn_start),
        .btn_stop      (btn_stop),
        .btn_reset     (btn_reset),
        .host_cmd_valid(host_cmd_valid),
        .host_cmd      (host_cmd),
        .host_cmd_ready(host_cmd_ready),
        .fsm_state     (fsm_state),
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .cmd_reset     (cmd_reset),
        .owner         (owner)
`ifdef CMD_DROP_COUNT_EN
       ,.drop_count    (drop_count)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_pulses();
        if (cmd_start) n_start++;
        if (cmd_stop)  n_stop++;
        if (cmd_reset) n_rst++;
    endtask

    task automatic clr_counts();
        n_start = 0;
        n_stop  = 0;
        n_rst   = 0;
    endtask

    initial begin
        rst_n = 1'b0; btn_start = 0; btn_stop = 0; btn_reset = 0;
        host_cmd_valid = 0; host_cmd = 2'b00; fsm_state = IDLE;
        own_at = FREE;
        clr_counts();
        repeat (3) tick();
        chk("rst_start", int'(cmd_start), 0);
        chk("rst_stop",  int'(cmd_stop),  0);
        chk("rst_reset", int'(cmd_reset), 0);
        chk("rst_owner", int'(owner), int'(FREE));
        chk("rst_ready", int'(host_cmd_ready), 1);
`ifdef CMD_DROP_COUNT_EN
        chk("rst_drop", int'(drop_count), 0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: bouncing local start -> exactly one pulse, LOCAL owner
        clr_counts();
        for (int i = 0; i < 30; i++) begin
            btn_start = (i == 0) || (i >= 2 && i <= 6);
            if (cmd_start) own_at = owner;
            count_pulses();
            tick();
        end
        chk("bounce_starts", n_start, 1);
        chk("bounce_others", n_stop + n_rst, 0);
        chk("bounce_owner_at_pulse", int'(own_at), int'(LOCAL));
        chk("bounce_owner_timeout", int'(owner), int'(FREE));

        // 2/3: host start, ready low one cycle, pulse two cycles after accept,
        //      then owner released 8 cycles after the pulse
        host_cmd_valid = 1; host_cmd = 2'b01;
        chk("hs_ready_pre", int'(host_cmd_ready), 1);
        tick();
        host_cmd_valid = 0;
        chk("hs_ready_low", int'(host_cmd_ready), 0);
        chk("hs_no_early",  int'(cmd_start), 0);
        tick();
        chk("hs_pulse", int'(cmd_start), 1);
        chk("hs_owner", int'(owner), int'(HOST));
        chk("hs_ready_back", int'(host_cmd_ready), 1);
        tick();
        chk("hs_single", int'(cmd_start), 0);
        repeat (6) tick();
        chk("to_owner_p7", int'(owner), int'(HOST));
        tick();
        chk("to_owner_p8", int'(owner), int'(FREE));
        repeat (3) tick();

        // 4: owner HOST, local stop dropped, local reset issues and frees
        clr_counts();
        for (int i = 0; i < 21; i++) begin
            btn_stop       = (i <= 5);
            btn_reset      = (i >= 2 && i <= 7);
            host_cmd_valid = (i == 3);
            host_cmd       = 2'b01;
            fsm_state      = (i <= 4) ? IDLE : RUN;
            if (i == 5)  chk("own_host_start", int'(cmd_start), 1);
            if (i == 9)  chk("own_pre_reset_owner", int'(owner), int'(HOST));
            if (i == 10) begin
                chk("own_reset_pulse", int'(cmd_reset), 1);
                chk("own_reset_free",  int'(owner), int'(FREE));
            end
            count_pulses();
            tick();
        end
        host_cmd_valid = 0;
        chk("own_stop_dropped", n_stop, 0);
        chk("own_reset_count", n_rst, 1);
`ifdef CMD_DROP_COUNT_EN
        chk("own_drop_cnt", int'(drop_count), 1);
`endif

        // 5: local and host stop pend together while FREE -> local wins
        clr_counts();
        fsm_state = RUN;
        for (int i = 0; i < 21; i++) begin
            btn_stop       = (i <= 5);
            host_cmd_valid = (i == 6);
            host_cmd       = 2'b10;
            if (i == 7) chk("sim_ready_pend", int'(host_cmd_ready), 0);
            if (i == 8) begin
                chk("sim_stop_pulse", int'(cmd_stop), 1);
                chk("sim_owner_local", int'(owner), int'(LOCAL));
            end
            if (i == 9) begin
                chk("sim_host_dropped", int'(cmd_stop), 0);
                chk("sim_ready_free", int'(host_cmd_ready), 1);
            end
            count_pulses();
            tick();
        end
        host_cmd_valid = 0;
        chk("sim_stop_count", n_stop, 1);
        chk("sim_owner_end", int'(owner), int'(FREE));
`ifdef CMD_DROP_COUNT_EN
        chk("sim_drop_cnt", int'(drop_count), 2);
`endif

        // 6: async reset with host command held and a button mid-debounce
        fsm_state = IDLE;
        btn_start = 1;
        repeat (3) tick();
        host_cmd_valid = 1; host_cmd = 2'b01;
        tick();
        host_cmd_valid = 0;
        chk("ar_pend_set", int'(host_cmd_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", int'(host_cmd_ready), 1);
        chk("ar_owner", int'(owner), int'(FREE));
        chk("ar_cmds", int'(cmd_start | cmd_stop | cmd_reset), 0);
`ifdef CMD_DROP_COUNT_EN
        chk("ar_drop", int'(drop_count), 0);
`endif
        btn_start = 0;
        repeat (3) tick();
        #2 rst_n = 1'b1;
        clr_counts();
        for (int i = 0; i < 20; i++) begin
            tick();
            count_pulses();
        end
        chk("ar_no_pulse", n_start + n_stop + n_rst, 0);
        chk("ar_owner_end", int'(owner), int'(FREE));

        // 7: reserved code, state-filtered start and reset, then a reset that issues
        clr_counts();
        for (int i = 0; i < 15; i++) begin
            host_cmd_valid = (i == 0) || (i == 2) || (i == 5) || (i == 8);
            host_cmd  = (i == 0) ? 2'b00 : (i == 2) ? 2'b01 : 2'b11;
            fsm_state = (i <= 4) ? RUN : (i <= 7) ? IDLE : RUN;
            if (i == 1)  chk("rsv_not_held", int'(host_cmd_ready), 1);
            if (i == 3)  chk("flt_start_held", int'(host_cmd_ready), 0);
            if (i == 4)  chk("flt_start_owner", int'(owner), int'(FREE));
            if (i == 10) chk("flt_reset_issue", int'(cmd_reset), 1);
            count_pulses();
            tick();
        end
        host_cmd_valid = 0;
        chk("flt_starts", n_start + n_stop, 0);
        chk("flt_resets", n_rst, 1);
`ifdef CMD_DROP_COUNT_EN
        chk("flt_drop_cnt", int'(drop_count), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
